oric_ram_arbiter: RTL
=====================

// Module: oric_ram_arbiter
// PURPOSE
//  Owns the single write/read port of the main Oric RAM (dpram port 1).
//  After reset it sequences a full-RAM clear, then serves the CPU/ULA bus.
//  Tape-loader byte writes are queued in a small FIFO and retired in CPU-idle cycles.
//  Port 2 of the dpram is then free for other users.
//  Sits between oricatmos/cassettecached and the dpram in the emu top level.
// PARAMETERS
//  AW         16     RAM address width; clear covers 2**AW bytes
//  FILL       8'h01  byte written to every location during clear
//  FIFO_AW    3      log2 of tape FIFO depth (8 entries)
// PORTS
//  clk_sys       in   1      system clock
//  RESET         in   1      synchronous, active-high reset
//  cpu_ad        in   AW     CPU/ULA address
//  cpu_d         in   8      CPU write data
//  cpu_cs        in   1      CPU access request; sampled every cycle
//  cpu_we        in   1      CPU write enable (valid with cpu_cs)
//  cpu_q         out  8      read data returned to CPU
//  tape_addr     in   AW     loader write address
//  tape_dout     in   8      loader write data
//  tape_wr       in   1      loader write strobe; one byte per cycle
//  tape_full     out  1      FIFO full; loader must hold tape_wr low
//  tape_done_in  in   1      loader finished (level, from cassette)
//  tape_done     out  1      all loader bytes committed to RAM (level)
//  ram_a         out  AW     to dpram a1
//  ram_d         out  8      to dpram di1
//  ram_ce        out  1      to dpram ce1
//  ram_we        out  1      to dpram we1
//  ram_q         in   8      from dpram do1 (1-cycle registered read)
//  clear_busy    out  1      high while clear in progress; CPU is held in reset
// BEHAVIOUR
//  - Reset values:
//    - state=CLEAR; clear counter=0; FIFO empty.
//    - clear_busy=1, tape_full=0, tape_done=0, cpu_q=0.
//  - All ram_* outputs are registered, which adds one cycle of request latency.
//  - CLEAR state:
//    - Each cycle issues ram_ce=1, ram_we=1, ram_a=counter, ram_d=FILL; counter then increments.
//    - The clear takes 2**AW cycles.
//    - After the write of address 2**AW-1 is issued, the next cycle enters RUN and drops clear_busy.
//    - cpu_cs is ignored and cpu_q is held at 0.
//    - Tape writes are accepted into the FIFO but not drained.
//  - RUN state, per cycle, by priority:
//    1. cpu_cs=1: ram_* takes cpu_ad/cpu_d/cpu_we with ram_ce=1. The CPU is never stalled.
//    2. else FIFO non-empty: pop the head entry and issue it with ram_ce=1, ram_we=1.
//    3. else idle: ram_ce=0, ram_we=0.
//  - CPU read timing: request at cycle N -> ram_* registered at N+1 -> ram_q valid at N+2.
//    - cpu_q registers ram_q only when the N+1 slot was a CPU read, so it is valid at N+3.
//    - Otherwise cpu_q holds its value.
//  - FIFO rules:
//    - tape_full = (count == 2**FIFO_AW).
//    - A tape_wr while full is dropped, and a sticky overflow flag sets (bench-visible, for assertions).
//    - A push and a pop in the same cycle keep count unchanged and are legal even when full.
//  - tape_done:
//    - done_pending latches on tape_done_in=1.
//    - tape_done=1 when done_pending=1, state=RUN, FIFO empty and no FIFO write in flight (ram_* stage).
//    - It falls when tape_done_in falls or on RESET.
//  - RESET mid-operation (CLEAR or RUN): FIFO flushed, pending tape bytes discarded, counter=0, CLEAR restarts.
//  - Address wrap: the clear counter is AW+1 bits wide; its MSB signals completion. There is no wrap in RUN.
// STRUCTURE
//  - Package oric_mem_pkg:
//    - typedef enum {CLEAR, RUN} ram_state_t;
//    - typedef struct {addr, data} tape_wr_t;
//    - localparam FILL default.
//  - Sub-module oric_sync_fifo #(W, AW):
//    - single clock; push/pop/full/empty/count; synchronous flush.
//    - Instantiated once for the tape path (W = AW+8).
//  - The top level holds the state machine, clear counter, arbitration mux, output registers and cpu_q capture.
// TESTING
//  - Reset with AW=16:
//    - clear_busy stays high exactly 65536 cycles.
//    - ram_we=1 with ram_d=8'h01 at every address 0..FFFF, each exactly once, in order.
//  - RUN, CPU writes 8'hA5 @0x1234, then reads @0x1234 -> cpu_q=8'hA5 three cycles after the read request.
//  - Tape burst of 8 writes while cpu_cs held high:
//    - tape_full rises after the 8th; ram_* shows only CPU accesses.
//    - After cpu_cs drops, the 8 bytes retire in order over 8 cycles.
//  - Simultaneous tape_wr and FIFO pop while full -> count stays 8, no overflow, next byte retained.
//  - tape_done_in=1 with 5 queued bytes -> tape_done rises only after the 5th write has left the ram_* stage.
//  - RESET asserted mid-clear at address 0x8000 with 3 queued tape bytes:
//    - clear restarts at 0, FIFO empty, queued bytes never written.

Source files
------------

// File: rtl/oric_mem_pkg.sv
// rtl/oric_mem_pkg.sv - shared types and defaults for the Oric main-RAM arbiter
package oric_mem_pkg;

    // Widest RAM address the tape path carries.
    localparam int TAPE_AW = 16;

    // Byte written to every RAM location while clearing after reset.
    localparam logic [7:0] FILL_DEFAULT = 8'h01;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } ram_state_t;

    typedef struct packed {
        logic [TAPE_AW-1:0] addr;
        logic [7:0]         data;
    } tape_wr_t;

endpackage

// File: rtl/oric_sync_fifo.sv
// rtl/oric_sync_fifo.sv - single-clock FIFO with show-ahead head and synchronous flush
module oric_sync_fifo #(
    parameter int W  = 24,
    parameter int AW = 3
) (
    input  logic          clk_sys,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  pop_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

    logic [W-1:0]  mem [0:2**AW-1];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == DEPTH);
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees a slot, so a push is legal even when full.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
    always_ff @(posedge clk_sys) begin
        if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + (AW+1)'(1);
            else if (do_pop && !do_push)
                count <= count - (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk_sys) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/oric_ram_arbiter.sv
// rtl/oric_ram_arbiter.sv - clears main RAM after reset, then arbitrates CPU and tape writes onto one port
module oric_ram_arbiter
    import oric_mem_pkg::*;
#(
    parameter int         AW      = 16,
    parameter logic [7:0] FILL    = FILL_DEFAULT,
    parameter int         FIFO_AW = 3
) (
    input  logic          clk_sys,
    input  logic          RESET,
    input  logic [AW-1:0] cpu_ad,
    input  logic [7:0]    cpu_d,
    input  logic          cpu_cs,
    input  logic          cpu_we,
    output logic [7:0]    cpu_q,
    input  logic [AW-1:0] tape_addr,
    input  logic [7:0]    tape_dout,
    input  logic          tape_wr,
    output logic          tape_full,
    input  logic          tape_done_in,
    output logic          tape_done,
    output logic [AW-1:0] ram_a,
    output logic [7:0]    ram_d,
    output logic          ram_ce,
    output logic          ram_we,
    input  logic [7:0]    ram_q,
    output logic          clear_busy
);

    localparam logic [FIFO_AW:0] FIFO_DEPTH = (FIFO_AW+1)'(2**FIFO_AW);

    ram_state_t       state;
    logic [AW:0]      clr_cnt;
    logic [AW:0]      clr_next;
    logic             slot_cpu_rd;
    logic             rd_valid;
    logic             slot_fifo;
    logic             done_pending;
    logic             tape_overflow;

    logic [AW+7:0]    fifo_q;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FIFO_AW:0] fifo_count;
    logic             fifo_pop;
    tape_wr_t         head;

    assign clr_next   = clr_cnt + (AW+1)'(1);
    assign head.addr  = TAPE_AW'(fifo_q[AW+7:8]);
    assign head.data  = fifo_q[7:0];
    // The queue only drains in RUN when the CPU leaves the port free.
    assign fifo_pop   = (state == RUN) && !cpu_cs && !fifo_empty;
    assign tape_full  = (fifo_count == FIFO_DEPTH);
    assign clear_busy = (state == CLEAR);
    assign tape_done  = done_pending && (state == RUN) && fifo_empty && !slot_fifo;

    oric_sync_fifo #(
        .W  (AW + 8),
        .AW (FIFO_AW)
    ) u_tape_fifo (
        .clk_sys   (clk_sys),
        .flush     (RESET),
        .push      (tape_wr),
        .push_data ({tape_addr, tape_dout}),
        .pop       (fifo_pop),
        .pop_data  (fifo_q),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Clear sequencer and port arbitration into the registered RAM request stage.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            state       <= CLEAR;
            clr_cnt     <= '0;
            ram_a       <= '0;
            ram_d       <= '0;
            ram_ce      <= 1'b0;
            ram_we      <= 1'b0;
            slot_cpu_rd <= 1'b0;
            slot_fifo   <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    ram_ce      <= 1'b1;
                    ram_we      <= 1'b1;
                    ram_a       <= clr_cnt[AW-1:0];
                    ram_d       <= FILL;
                    clr_cnt     <= clr_next;
                    slot_cpu_rd <= 1'b0;
                    slot_fifo   <= 1'b0;
                    // The counter MSB flips as the last address is issued.
                    if (clr_next[AW]) state <= RUN;
                end
                RUN: begin
                    if (cpu_cs) begin
                        ram_ce      <= 1'b1;
                        ram_we      <= cpu_we;
                        ram_a       <= cpu_ad;
                        ram_d       <= cpu_d;
                        slot_cpu_rd <= !cpu_we;
                        slot_fifo   <= 1'b0;
                    end else if (!fifo_empty) begin
                        ram_ce      <= 1'b1;
                        ram_we      <= 1'b1;
                        ram_a       <= head.addr[AW-1:0];
                        ram_d       <= head.data;
                        slot_cpu_rd <= 1'b0;
                        slot_fifo   <= 1'b1;
                    end else begin
                        ram_ce      <= 1'b0;
                        ram_we      <= 1'b0;
                        slot_cpu_rd <= 1'b0;
                        slot_fifo   <= 1'b0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // Capture RAM read data only in the cycle after a CPU read slot reached the RAM.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            rd_valid <= 1'b0;
            cpu_q    <= '0;
        end else begin
            rd_valid <= slot_cpu_rd;
            if (rd_valid) cpu_q <= ram_q;
        end
    end

    // Loader completion level and sticky record of bytes lost to a full queue.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            done_pending  <= 1'b0;
            tape_overflow <= 1'b0;
        end else begin
            done_pending <= tape_done_in;
            if (tape_wr && fifo_full && !fifo_pop) tape_overflow <= 1'b1;
        end
    end

endmodule
